approx_err_monitor: RTL and testbench
=====================================

Name: approx_err_monitor

Overview:
Online error-characterisation stage that sits directly downstream of the 8x8 approximate multipliers. It consumes (A, B, R) triples from the multiplier under test over a valid/ready handshake. It recomputes the exact product internally and accumulates error statistics over a programmed number of samples: error count, sum of error distance, and maximum error distance with its operands. Results are held for readout until the next run.

Parameters:
CNT_W, 32, width of sample counters and of num_samples
SUM_W, 48, width of the error-distance accumulator (minimum 17)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  single-cycle pulse; begins a run
num_samples  input  CNT_W  samples per run; sampled on an accepted start
in_valid  input  1  operand/result triple valid
in_ready  output  1  block accepts the triple this cycle
in_a  input  8  multiplicand A fed to the multiplier
in_b  input  8  multiplier B fed to the multiplier
in_r  input  16  approximate product R from the multiplier
busy  output  1  high in RUN or DRAIN
done  output  1  high in DONE; statistics valid
sample_count  output  CNT_W  samples retired this run
err_count  output  CNT_W  retired samples with R != A*B
sum_ed  output  SUM_W  sum of |R - A*B|, saturating
max_ed  output  16  largest |R - A*B| this run
max_a  output  8  A of the max_ed sample
max_b  output  8  B of the max_ed sample

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready 0, busy 0, done 0, all statistics 0, pipeline valids 0. Reset mid-run aborts the run and discards in-flight samples.
- FSM states:
  - IDLE: waits for start.
  - RUN: accepting samples.
  - DRAIN: all samples accepted, pipeline still emptying.
  - DONE: statistics stable.
- FSM transitions:
  - IDLE/DONE + start: latch num_samples, clear all statistics and the accept counter, go to RUN. If num_samples == 0, go to DONE instead, with zero statistics.
  - RUN: in_ready = 1 while accepted < num_samples. A transfer occurs when in_valid && in_ready. When the transfer that makes accepted == num_samples completes, in_ready drops next cycle and the state goes to DRAIN.
  - DRAIN -> DONE in the cycle after the last sample retires. sample_count then equals num_samples.
  - start while busy is ignored.
  - in_ready is a registered function of state and count only; it never depends on in_valid.
- Pipeline, fixed latency 2:
  - Edge t (transfer): stage 1 registers a, b, r.
  - Edge t+1: stage 2 registers exact = a*b (16-bit unsigned) and ed = |r - exact| (16-bit), computed as a 17-bit signed difference.
  - Edge t+2: statistics update, visible after that edge.
  - Throughput is one sample per cycle; gaps in in_valid insert bubbles and do not update statistics.
- Statistics update per retired sample:
  - sample_count += 1.
  - err_count += (ed != 0).
  - sum_ed += ed, saturating at 2^SUM_W - 1 and sticking there.
  - max_ed/max_a/max_b update only when ed > max_ed (strictly), so the first occurrence wins on ties.
  - A sample with ed == 0 never updates max_a/max_b; they stay 0 if the run has no errors.
- done and statistics hold in DONE indefinitely. A new start clears them on the same edge it is accepted.
- Counters are never wrapped: sample_count cannot exceed num_samples, which is at most 2^CNT_W - 1.

Test Plan:
- Exact reference: start, num_samples=65536, all (A,B) pairs with R=A*B, continuous valid -> done, sample_count=65536, err_count=0, sum_ed=0, max_ed=0, max_a=max_b=0.
- Single worst case: num_samples=3, triples (3,5,15), (255,255,0), (2,2,5) -> err_count=2, sum_ed=65026, max_ed=65025, max_a=255, max_b=255. done rises exactly 3 cycles after the third transfer edge.
- Tie and bubbles: num_samples=4, with in_valid low 2 cycles between samples: (1,1,3) ED2, (2,1,4) ED2, (0,0,0), (4,4,14) ED2 -> max_a=1, max_b=1, err_count=3, sum_ed=6. in_ready=0 from the cycle after the 4th transfer.
- Zero-length and ignored start: start with num_samples=0 -> done next cycle, all stats 0. Then start num_samples=2 with a second start pulse mid-run -> ignored; run completes after 2 samples.
- Saturation: SUM_W=17, num_samples=3, three (255,255,0) samples -> sum_ed=131071, err_count=3.
- Reset mid-run: rst asserted after 5 of 10 transfers, with 2 samples still in the pipeline -> next cycle busy=0, done=0, all stats 0. A fresh start then runs cleanly.

Source files
------------

// File: rtl/approx_err_monitor.sv
// Error-statistics monitor for 8x8 approximate multipliers. It recomputes the exact
// product in a 2-stage pipeline and accumulates error count, error-distance sum and worst case.
module approx_err_monitor #(
   parameter int CNT_W = 32,
   parameter int SUM_W = 48
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   input  logic [15:0]      in_r,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sample_count,
   output logic [CNT_W-1:0] err_count,
   output logic [SUM_W-1:0] sum_ed,
   output logic [15:0]      max_ed,
   output logic [7:0]       max_a,
   output logic [7:0]       max_b
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] acc,
                                                input logic [15:0] inc);
      logic [SUM_W:0] wide;
      wide = {1'b0, acc} + (SUM_W+1)'(inc);
      sat_add = wide[SUM_W] ? {SUM_W{1'b1}} : wide[SUM_W-1:0];
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] num_q, num_d, acc_q, acc_d;
   logic             in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;
   logic             xfer_s, start_ok_s;

   logic             s1_valid_q, s2_valid_q;
   logic [7:0]       s1_a_q, s1_b_q, s2_a_q, s2_b_q;
   logic [15:0]      s1_r_q, s2_ed_q;
   logic [15:0]      exact_s, ed_s;
   logic signed [16:0] diff_s, neg_s;

   logic [CNT_W-1:0] cnt_q, cnt_d, err_q, err_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [15:0]      max_ed_q, max_ed_d;
   logic [7:0]       max_a_q, max_a_d, max_b_q, max_b_d;

   assign xfer_s     = in_valid && in_ready_q;
   assign start_ok_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   // Run-control FSM next state, accept counter and registered handshake/status
   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      acc_d   = acc_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_ok_s) begin
               num_d   = num_samples;
               acc_d   = '0;
               state_d = (num_samples == '0) ? S_DONE : S_RUN;
            end else begin
               state_d = state_q;
            end
         end
         S_RUN: begin
            if (xfer_s) begin
               acc_d = acc_q + CNT_ONE;
               if ((acc_q + CNT_ONE) == num_q) state_d = S_DRAIN;
               else                            state_d = S_RUN;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            if (cnt_q == num_q) state_d = S_DONE;
            else                state_d = S_DRAIN;
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d = (state_d == S_RUN) && (acc_d < num_d);
      busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
      done_d     = (state_d == S_DONE);
   end

   // Exact product and absolute error distance of the stage-1 sample
   always_comb begin
      exact_s = {8'd0, s1_a_q} * {8'd0, s1_b_q};
      diff_s  = $signed({1'b0, s1_r_q}) - $signed({1'b0, exact_s});
      neg_s   = -diff_s;
      ed_s    = diff_s[16] ? neg_s[15:0] : diff_s[15:0];
   end

   // Statistics next state; an accepted start wipes the previous run's results
   always_comb begin
      cnt_d    = cnt_q;
      err_d    = err_q;
      sum_d    = sum_q;
      max_ed_d = max_ed_q;
      max_a_d  = max_a_q;
      max_b_d  = max_b_q;
      if (start_ok_s) begin
         cnt_d    = '0;
         err_d    = '0;
         sum_d    = '0;
         max_ed_d = 16'd0;
         max_a_d  = 8'd0;
         max_b_d  = 8'd0;
      end else if (s2_valid_q) begin
         cnt_d = cnt_q + CNT_ONE;
         err_d = (s2_ed_q != 16'd0) ? (err_q + CNT_ONE) : err_q;
         sum_d = sat_add(sum_q, s2_ed_q);
         if (s2_ed_q > max_ed_q) begin
            max_ed_d = s2_ed_q;
            max_a_d  = s2_a_q;
            max_b_d  = s2_b_q;
         end else begin
            max_ed_d = max_ed_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State, pipeline and statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         num_q      <= '0;
         acc_q      <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_a_q     <= 8'd0;
         s1_b_q     <= 8'd0;
         s1_r_q     <= 16'd0;
         s2_a_q     <= 8'd0;
         s2_b_q     <= 8'd0;
         s2_ed_q    <= 16'd0;
         cnt_q      <= '0;
         err_q      <= '0;
         sum_q      <= '0;
         max_ed_q   <= 16'd0;
         max_a_q    <= 8'd0;
         max_b_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         acc_q      <= acc_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         s1_valid_q <= xfer_s;
         s2_valid_q <= s1_valid_q;
         if (xfer_s) begin
            s1_a_q <= in_a;
            s1_b_q <= in_b;
            s1_r_q <= in_r;
         end
         if (s1_valid_q) begin
            s2_a_q  <= s1_a_q;
            s2_b_q  <= s1_b_q;
            s2_ed_q <= ed_s;
         end
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         sum_q    <= sum_d;
         max_ed_q <= max_ed_d;
         max_a_q  <= max_a_d;
         max_b_q  <= max_b_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign sample_count = cnt_q;
   assign err_count    = err_q;
   assign sum_ed       = sum_q;
   assign max_ed       = max_ed_q;
   assign max_a        = max_a_q;
   assign max_b        = max_b_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Bench for approx_err_monitor: directed and random runs checked against a queue-based
// reference that derives the statistics from the list of accepted triples.
module tb_approx_err_monitor;

   logic        clk = 1'b0;
   logic        rst, start, in_valid;
   logic [31:0] num_samples;
   logic [7:0]  in_a, in_b;
   logic [15:0] in_r;

   logic        rdy, busy, done, rdy17, busy17, done17;
   logic [31:0] cnt, err, cnt17, err17;
   logic [47:0] sum;
   logic [16:0] sum17;
   logic [15:0] med, med17;
   logic [7:0]  ma, mb, ma17, mb17;

   int tests = 0;
   int fails = 0;
   logic [7:0]  qa[$], qb[$];
   logic [15:0] qr[$];

   always #5 clk = ~clk;

   approx_err_monitor #(.CNT_W(32), .SUM_W(48)) dut (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(rdy), .in_a(in_a), .in_b(in_b), .in_r(in_r),
      .busy(busy), .done(done), .sample_count(cnt), .err_count(err), .sum_ed(sum),
      .max_ed(med), .max_a(ma), .max_b(mb));

   approx_err_monitor #(.CNT_W(32), .SUM_W(17)) dut17 (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(rdy17), .in_a(in_a), .in_b(in_b), .in_r(in_r),
      .busy(busy17), .done(done17), .sample_count(cnt17), .err_count(err17), .sum_ed(sum17),
      .max_ed(med17), .max_a(ma17), .max_b(mb17));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [31:0] n);
      qa.delete(); qb.delete(); qr.delete();
      num_samples = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
      int   budget;
      logic took;
      budget = 0;
      took   = 1'b0;
      in_a = a; in_b = b; in_r = r;
      in_valid = 1'b1;
      while (!took && budget < 50) begin
         took = rdy;
         tick();
         budget++;
      end
      in_valid = 1'b0;
      if (took) begin
         qa.push_back(a); qb.push_back(b); qr.push_back(r);
      end else begin
         tests++;
         fails++;
         $error("FAIL send_timeout: observed in_ready 0 expected transfer within 50 cycles");
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      chk("done_reached", done, 1'b1);
   endtask

   // reference: statistics recomputed from the accepted triples with plain integer arithmetic
   task automatic check_model(input string tag);
      longint s48, s17, ed, ex, mx;
      int     ec, xa, xb;
      s48 = 0; s17 = 0; ec = 0; mx = 0; xa = 0; xb = 0;
      foreach (qa[i]) begin
         ex = longint'(qa[i]) * longint'(qb[i]);
         ed = (longint'(qr[i]) > ex) ? longint'(qr[i]) - ex : ex - longint'(qr[i]);
         if (ed != 0) ec++;
         s48 = (s48 + ed > 64'(48'hFFFF_FFFF_FFFF)) ? 64'(48'hFFFF_FFFF_FFFF) : s48 + ed;
         s17 = (s17 + ed > 131071) ? 131071 : s17 + ed;
         if (ed > mx) begin
            mx = ed; xa = qa[i]; xb = qb[i];
         end
      end
      chk({tag, ".done"},  done, 1'b1);
      chk({tag, ".busy"},  busy, 1'b0);
      chk({tag, ".ready"}, rdy, 1'b0);
      chk({tag, ".count"}, cnt, qa.size());
      chk({tag, ".err"},   err, ec);
      chk({tag, ".sum"},   sum, s48);
      chk({tag, ".max_ed"}, med, mx);
      chk({tag, ".max_a"}, ma, xa);
      chk({tag, ".max_b"}, mb, xb);
      chk({tag, ".sum17"}, sum17, s17);
      chk({tag, ".err17"}, err17, ec);
   endtask

   initial begin
      logic [7:0]  ra, rb;
      logic [15:0] rr;
      int          n;

      rst = 1'b1; start = 1'b0; in_valid = 1'b0;
      num_samples = 32'd0; in_a = 8'd0; in_b = 8'd0; in_r = 16'd0;
      tick(); tick();
      rst = 1'b0;
      chk("reset.ready", rdy, 1'b0);
      chk("reset.busy", busy, 1'b0);
      chk("reset.done", done, 1'b0);
      chk("reset.count", cnt, 32'd0);
      chk("reset.sum", sum, 48'd0);
      chk("reset.max_ed", med, 16'd0);

      // exhaustive exact products
      start_run(32'd65536);
      for (int a = 0; a < 256; a++)
         for (int b = 0; b < 256; b++)
            send(8'(a), 8'(b), 16'(a * b));
      wait_done();
      check_model("exact");
      chk("exact.count_abs", cnt, 32'd65536);

      // single worst case, done exactly three edges after last transfer
      start_run(32'd3);
      send(8'd3, 8'd5, 16'd15);
      send(8'd255, 8'd255, 16'd0);
      send(8'd2, 8'd2, 16'd5);
      chk("worst.done_t0", done, 1'b0);
      tick();
      chk("worst.done_t1", done, 1'b0);
      tick();
      chk("worst.done_t2", done, 1'b0);
      tick();
      chk("worst.done_t3", done, 1'b1);
      check_model("worst");
      chk("worst.sum_abs", sum, 48'd65026);
      chk("worst.max_abs", med, 16'd65025);

      // ties with bubbles: first occurrence wins
      start_run(32'd4);
      send(8'd1, 8'd1, 16'd3);  tick(); tick();
      send(8'd2, 8'd1, 16'd4);  tick(); tick();
      send(8'd0, 8'd0, 16'd0);  tick(); tick();
      send(8'd4, 8'd4, 16'd14);
      chk("tie.ready_drop", rdy, 1'b0);
      wait_done();
      check_model("tie");
      chk("tie.max_a_abs", ma, 8'd1);
      chk("tie.err_abs", err, 32'd3);

      // zero-length run
      start_run(32'd0);
      chk("zero.done_next", done, 1'b1);
      check_model("zero");

      // start while busy is ignored
      start_run(32'd2);
      send(8'd7, 8'd9, 16'd60);
      num_samples = 32'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ignstart.busy", busy, 1'b1);
      send(8'd10, 8'd10, 16'd99);
      wait_done();
      check_model("ignstart");

      // saturation of the 17-bit accumulator
      start_run(32'd3);
      for (int i = 0; i < 3; i++) send(8'd255, 8'd255, 16'd0);
      wait_done();
      check_model("sat");
      chk("sat.sum17_abs", sum17, 17'd131071);

      // reset mid-run with samples still in the pipeline
      start_run(32'd10);
      for (int i = 0; i < 5; i++) send(8'($urandom), 8'($urandom), 16'($urandom));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid.busy", busy, 1'b0);
      chk("rstmid.done", done, 1'b0);
      chk("rstmid.ready", rdy, 1'b0);
      chk("rstmid.count", cnt, 32'd0);
      chk("rstmid.sum", sum, 48'd0);
      tick(); tick(); tick();
      chk("rstmid.count_later", cnt, 32'd0);
      chk("rstmid.err_later", err, 32'd0);

      // random runs with random errors and bubbles
      for (int run = 0; run < 6; run++) begin
         n = $urandom_range(1, 30);
         start_run(32'(n));
         for (int i = 0; i < n; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 2))
               0:       rr = 16'(int'(ra) * int'(rb));
               1:       rr = 16'(int'(ra) * int'(rb)) ^ 16'($urandom_range(1, 255));
               default: rr = 16'($urandom);
            endcase
            send(ra, rb, rr);
            repeat ($urandom_range(0, 2)) tick();
         end
         wait_done();
         check_model($sformatf("rand%0d", run));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
